// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified instruction/data memory port arbiter.
// Holds the sequencer state encoding, the requester ids and the default
// geometry (word-address width, data width, wait timeout).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    // Requester ids; also the encoding of the last_grant register.
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    localparam int unsigned DefAddrW   = 13;
    localparam int unsigned DefDataW   = 32;
    localparam int unsigned DefTimeout = 255;

    // Width of a counter that must be able to hold the value max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshake signals of the
// unified memory port.
//   master : arbiter side (takes requests, drives acks and the memory strobe)
//   slave  : system side (requesters and the memory itself)
// Signals:
//   if_req/if_addr -> if_ack/if_rdata                  fetch requester
//   dm_req/dm_we/dm_addr/dm_wdata -> dm_ack/dm_rdata   data requester
//   mem_req/mem_we/mem_addr/mem_wdata -> mem_rdata/mem_ready   memory
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = mem_arb_pkg::DefAddrW,
    parameter int unsigned DATA_W = mem_arb_pkg::DefDataW
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  if_req, if_addr,
        output if_ack, if_rdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_ack, dm_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output if_req, if_addr,
        input  if_ack, if_rdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_ack, dm_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Grant selector for the fetch / data requesters.
// Build option MEM_ARB_RR_EN:
//   defined   : round-robin on conflict, using a last_grant register that
//               resets to REQ_IF and updates on every taken grant.
//   undefined : fixed priority, DM always wins a conflict; no state.
// Ports:
//   i_clk, i_rst, i_take  (round-robin build only) clock, sync reset,
//                         grant-taken strobe that updates last_grant
//   i_if_req, i_dm_req    request lines
//   o_valid               at least one request present
//   o_id                  selected requester (REQ_IF / REQ_DM)
module mem_arb_pick
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_take,
`endif
    input  logic i_if_req,
    input  logic i_dm_req,
    output logic o_valid,
    output logic o_id
);

`ifdef MEM_ARB_RR_EN
    logic r_last_grant;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_grant <= REQ_IF;
        end else if (i_take) begin
            r_last_grant <= o_id;
        end
    end
`endif

    always_comb begin
        o_valid = i_if_req | i_dm_req;
        o_id    = REQ_DM;
        if (i_if_req && i_dm_req) begin
`ifdef MEM_ARB_RR_EN
            // Conflict: hand the port to whoever did not have it last.
            o_id = (r_last_grant == REQ_IF) ? REQ_DM : REQ_IF;
`else
            o_id = REQ_DM;
`endif
        end else if (i_if_req) begin
            o_id = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequencer/arbiter sharing the single unified memory port between the
// fetch stage (IF) and the data-memory stage (DM). One access at a time:
// IDLE (grant) -> WAIT (memory handshake, timeout) -> DONE (ack pulse).
// Build option MEM_ARB_RR_EN selects round-robin conflict arbitration in
// mem_arb_pick; without it DM has fixed priority.
// Ports:
//   i_clk   clock, rising edge
//   i_rst   synchronous active-high reset
//   i_halt  blocks new grants; an in-flight access still completes
//   bus     master modport: requester handshakes and memory strobe
//   o_err   sticky timeout flag, cleared only by reset
//   o_idle  high in IDLE (nothing in flight)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned DATA_W  = DefDataW,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_halt,
    mem_port_arbiter_if.master bus,
    output logic               o_err,
    output logic               o_idle
);

    localparam int unsigned     CntW   = cnt_width(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    state_e            r_state, w_state_d;
    logic              r_id, w_id_d;
    logic [ADDR_W-1:0] r_addr, w_addr_d;
    logic              r_we, w_we_d;
    logic [DATA_W-1:0] r_wdata, w_wdata_d;
    logic [DATA_W-1:0] r_rdata, w_rdata_d;
    logic [CntW-1:0]   r_cnt, w_cnt_d;
    logic              r_err, w_err_d;
    logic              r_if_ack, w_if_ack_d;
    logic              r_dm_ack, w_dm_ack_d;

    logic              w_pick_valid;
    logic              w_pick_id;
    logic              w_mem_req;
`ifdef MEM_ARB_RR_EN
    logic              w_take;
`endif

    mem_arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_take   (w_take),
`endif
        .i_if_req (bus.if_req),
        .i_dm_req (bus.dm_req),
        .o_valid  (w_pick_valid),
        .o_id     (w_pick_id)
    );

`ifdef MEM_ARB_RR_EN
    assign w_take = (r_state == StIdle) && !i_halt && w_pick_valid;
`endif

    always_comb begin
        w_state_d  = r_state;
        w_id_d     = r_id;
        w_addr_d   = r_addr;
        w_we_d     = r_we;
        w_wdata_d  = r_wdata;
        w_rdata_d  = r_rdata;
        w_cnt_d    = r_cnt;
        w_err_d    = r_err;
        w_if_ack_d = 1'b0;
        w_dm_ack_d = 1'b0;

        case (r_state)
            StIdle: begin
                if (!i_halt && w_pick_valid) begin
                    w_id_d  = w_pick_id;
                    w_cnt_d = '0;
                    if (w_pick_id == REQ_DM) begin
                        w_addr_d  = bus.dm_addr;
                        w_we_d    = bus.dm_we;
                        w_wdata_d = bus.dm_we ? bus.dm_wdata : '0;
                    end else begin
                        w_addr_d  = bus.if_addr;
                        w_we_d    = 1'b0;
                        w_wdata_d = '0;
                    end
                    w_state_d = StWait;
                end
            end
            StWait: begin
                if (bus.mem_ready) begin
                    w_rdata_d  = r_we ? '0 : bus.mem_rdata;
                    w_if_ack_d = (r_id == REQ_IF);
                    w_dm_ack_d = (r_id == REQ_DM);
                    w_state_d  = StDone;
                end else if (r_cnt == CntMax) begin
                    // Memory never answered: abort, but still ack so the
                    // pipeline is released.
                    w_err_d    = 1'b1;
                    w_rdata_d  = '0;
                    w_if_ack_d = (r_id == REQ_IF);
                    w_dm_ack_d = (r_id == REQ_DM);
                    w_state_d  = StDone;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_id     <= REQ_IF;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_id     <= w_id_d;
            r_addr   <= w_addr_d;
            r_we     <= w_we_d;
            r_wdata  <= w_wdata_d;
            r_rdata  <= w_rdata_d;
            r_cnt    <= w_cnt_d;
            r_err    <= w_err_d;
            r_if_ack <= w_if_ack_d;
            r_dm_ack <= w_dm_ack_d;
        end
    end

    // Strobe is dropped in the last WAIT cycle of a timed-out access.
    assign w_mem_req     = (r_state == StWait) && (r_cnt != CntMax);

    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_req & r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.if_ack    = r_if_ack;
    assign bus.dm_ack    = r_dm_ack;
    assign bus.if_rdata  = r_rdata;
    assign bus.dm_rdata  = r_rdata;

    assign o_err  = r_err;
    assign o_idle = (r_state == StIdle);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single unified instruction/data memory of the pipelined CPU. It shares one memory port between two requesters: the fetch stage (IF) and the data-memory stage (DM). It drives the memory-side handshake, watches for a stalled memory with a timeout counter, and returns one-cycle acknowledges that the pipeline uses as its stall release. It stops accepting new accesses once `halt` is raised, so the memory image is stable for end-of-run checking.

## Interface
- `ADDR_W`, default 13: word-address width; 8192 words.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 255: maximum cycles in WAIT before an access is aborted.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `halt`  in  1  CPU halt; blocks new grants.
- `if_req`  in  1  fetch request; held high until `if_ack`.
- `if_addr`  in  ADDR_W  fetch word address.
- `if_ack`  out  1  one-cycle completion pulse for fetch.
- `if_rdata`  out  DATA_W  fetch data; valid only while `if_ack` is high.
- `dm_req`  in  1  data request; held high until `dm_ack`.
- `dm_we`  in  1  data write enable.
- `dm_addr`  in  ADDR_W  data word address.
- `dm_wdata`  in  DATA_W  store data.
- `dm_ack`  out  1  one-cycle completion pulse for data.
- `dm_rdata`  out  DATA_W  load data; valid only while `dm_ack` is high.
- `mem_req`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; sampled while `mem_ready` is high.
- `mem_ready`  in  1  memory done; may be high in the same cycle `mem_req` rises.
- `err`  out  1  sticky timeout flag.
- `idle`  out  1  high in IDLE while no access is in flight.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Sample `if_req` and `dm_req`.
  - If `halt` is high, make no grant and stay in IDLE.
  - Otherwise pick a requester, latch its address, write enable, write data and id into the request registers, and go to WAIT.
  - With no request pending, stay in IDLE.
- WAIT:
  - `mem_req` is high and the `mem_*` outputs come from the request registers.
  - Timeout counter starts at 0 and increments every WAIT cycle.
  - `mem_ready` high: latch `mem_rdata` (0 on a write), go to DONE.
  - Counter reaches TIMEOUT with no ready: drop `mem_req`, set `err`, latch rdata = 0, go to DONE.
- DONE:
  - Pulse the ack of the granted requester for one cycle with the latched rdata, then go to IDLE.
  - The requester may change `req`/`addr` on the same edge where it sees ack.
- Arbitration: a single request is granted directly. For simultaneous requests, see Configuration. `last_grant` resets to IF, so the first conflict after reset goes to DM in both builds.
- Writes: `mem_we` = latched `dm_we`. IF accesses are always reads.
- `err` stays set until `rst`. The aborted access still gets its ack.
- `halt` raised mid-access: the in-flight access completes normally and no further grants are made.
- `rst` at any time: next cycle the FSM is IDLE, no ack is issued for the aborted access, and all counters and registers clear.

## Timing
- Values after reset:
  - `mem_req`, `mem_we`, `if_ack`, `dm_ack` and `err` are 0.
  - `mem_addr`, `mem_wdata`, `if_rdata` and `dm_rdata` are 0.
  - `idle` is 1.
- Minimum latency is 3 cycles, request to ack: IDLE (grant) → WAIT (`mem_ready` = 1) → DONE (ack).
- Each extra wait cycle from the memory adds 1 cycle.
- The port sustains at most one access per 3 cycles.
- Timeout abort: ack arrives TIMEOUT + 2 cycles after the grant cycle.
- `mem_*` outputs are registered; nothing combinational passes from requester inputs to memory outputs.
- `ack` and `rdata` are registered.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin on conflict: grant the requester not recorded in `last_grant`.
  - `last_grant` updates on every grant.
- `MEM_ARB_RR_EN` undefined:
  - Fixed priority: DM always wins, so loads and stores drain ahead of fetch.
  - `last_grant` is unused.

## Structure
- Package `mem_arb_pkg` holds:
  - State enum (IDLE, WAIT, DONE).
  - Requester id constants (REQ_IF = 0, REQ_DM = 1).
  - Default ADDR_W, DATA_W and TIMEOUT.
- One sub-module: `mem_arb_pick`, the grant selector with the `last_grant` register and the `MEM_ARB_RR_EN` logic.
- The FSM, request registers and timeout counter live in the top module.

## Test plan
- Lone fetch: `if_req` = 1, `if_addr` = 0x010, memory ready immediately with data 0x2002_0005 → `if_ack` in the 3rd cycle, `if_rdata` = 0x2002_0005, `mem_we` = 0.
- Store: `dm_we` = 1, `dm_addr` = 0x1FFF, `dm_wdata` = 0xCAFE_F00D, memory ready after 4 wait cycles → `mem_we` = 1 during WAIT, `dm_ack` 6 cycles after the grant, `dm_rdata` = 0.
- Conflict: `if_req` and `dm_req` both held high for 4 accesses → with `MEM_ARB_RR_EN`, grant order DM, IF, DM, IF; without it, DM four times while IF stalls.
- Timeout: TIMEOUT = 8, `mem_ready` tied 0 → `mem_req` drops after 8 WAIT cycles, `err` = 1 and stays high, ack arrives with rdata 0.
- Halt: `halt` rises during WAIT of a DM read → that read acks normally, a pending `if_req` is never granted, and `idle` goes to 1.
- Reset mid-WAIT: `rst` pulsed for 1 cycle → next cycle `mem_req` = 0, no ack, `err` = 0, FSM in IDLE.
